ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit_pkg.sv | 17 +
 rtl/ex_muldiv_unit_if.sv | 30 +++
 rtl/ex_muldiv_unit_md_sign_fix.sv | 12 +
 rtl/ex_muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - shared opcode, state and constant definitions for the muldiv unit
package cpu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULH = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_REM  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH_DEFAULT-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - issue/result bundle between ID/EX, the muldiv unit and EX/MEM
interface ex_muldiv_unit_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       dest_in;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       dest_out;
  logic             div_zero;

  modport master (
    output start, op, op_a, op_b, dest_in, flush,
    input  stall, busy, result_valid, result, dest_out, div_zero
  );

  modport slave (
    input  start, op, op_a, op_b, dest_in, flush,
    output stall, busy, result_valid, result, dest_out, div_zero
  );

endinterface

// File: rtl/ex_muldiv_unit_md_sign_fix.sv
// rtl/ex_muldiv_unit_md_sign_fix.sv - conditional two's-complement negation (abs value / sign restore)
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] out
);

  assign out = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative radix-2 MUL/MULH/DIV/REM with pipeline stall
// MULDIV_EARLY_OUT_EN: zero operands bypass the iteration phase.
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  ex_muldiv_unit_if.slave io
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [1:0]         op_r;
  logic [4:0]         dest_r;
  logic               a_sign;
  logic               b_sign;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               issue;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] fix_in;
  logic [2*WIDTH-1:0] fix_out;
  logic               fix_neg;
  logic [WIDTH-1:0]   res_sel;

  md_sign_fix #(.W(WIDTH)) u_fix_a (.val(io.op_a), .neg(io.op_a[WIDTH-1]), .out(a_mag));
  md_sign_fix #(.W(WIDTH)) u_fix_b (.val(io.op_b), .neg(io.op_b[WIDTH-1]), .out(b_mag));
  md_sign_fix #(.W(2*WIDTH)) u_fix_res (.val(fix_in), .neg(fix_neg), .out(fix_out));

  assign issue    = (state == IDLE) & io.start & !io.flush;
  assign io.stall = rst & !io.flush & (issue | (state == CALC));
  assign io.busy  = (state != IDLE);

  // Multiply keeps the product in {acc, lo}; divide keeps remainder in acc, quotient shifts into lo.
  assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, a_abs} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc, lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_abs};

  always_comb begin
    fix_in  = {acc, lo};
    fix_neg = a_sign ^ b_sign;
    if (op_r == MD_REM) begin
      fix_in  = {{WIDTH{1'b0}}, acc};
      fix_neg = a_sign;
    end else if (op_r == MD_DIV) begin
      fix_in  = {{WIDTH{1'b0}}, lo};
    end
  end

  always_comb begin
    res_sel = fix_out[WIDTH-1:0];
    if (op_r == MD_MULH)
      res_sel = fix_out[2*WIDTH-1:WIDTH];
    else if ((op_r == MD_DIV) && (b_abs == '0))
      res_sel = WIDTH'(DIV_ZERO_QUOT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      count           <= '0;
      op_r            <= MD_MUL;
      dest_r          <= '0;
      a_sign          <= 1'b0;
      b_sign          <= 1'b0;
      a_abs           <= '0;
      b_abs           <= '0;
      acc             <= '0;
      lo              <= '0;
      io.result_valid <= 1'b0;
      io.result       <= '0;
      io.dest_out     <= '0;
      io.div_zero     <= 1'b0;
    end else begin
      io.result_valid <= 1'b0;
      if (io.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (io.start) begin
              a_sign <= io.op_a[WIDTH-1];
              b_sign <= io.op_b[WIDTH-1];
              a_abs  <= a_mag;
              b_abs  <= b_mag;
              op_r   <= io.op;
              dest_r <= io.dest_in;
              count  <= '0;
              acc    <= '0;
              lo     <= io.op[1] ? a_mag : b_mag;
`ifdef MULDIV_EARLY_OUT_EN
              if ((io.op_a == '0) || (io.op_b == '0)) begin
                state <= DONE;
                acc   <= (io.op[1] && (io.op_b == '0)) ? a_mag : '0;
                lo    <= '0;
              end else begin
                state <= CALC;
              end
`else
              state <= CALC;
`endif
            end
          end
          CALC: begin
            if (op_r[1]) begin
              if (!div_trial[WIDTH]) begin
                acc <= div_trial[WIDTH-1:0];
                lo  <= {lo[WIDTH-2:0], 1'b1};
              end else begin
                acc <= div_shift[WIDTH-1:0];
                lo  <= {lo[WIDTH-2:0], 1'b0};
              end
            end else begin
              {acc, lo} <= {mul_sum, lo[WIDTH-1:1]};
            end
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH-1))
              state <= DONE;
          end
          DONE: begin
            io.result       <= res_sel;
            io.dest_out     <= dest_r;
            io.div_zero     <= op_r[1] & (b_abs == '0);
            io.result_valid <= 1'b1;
            state           <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit with a longint reference model
module tb_ex_muldiv_unit;

  localparam int W = 32;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t sbq[$];
  bit   early_en;

  ex_muldiv_unit_if #(.WIDTH(W)) mif ();

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .io (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); return p[31:0]; end
      2'b01: begin p = 64'(sa * sb); return p[63:32]; end
      2'b10: if (b == 0) return 32'hFFFF_FFFF; else return 32'(sa / sb);
      default: if (b == 0) return a; else return 32'(sa % sb);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst && mif.result_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("result", mif.result, e.res);
        check("dest_out", mif.dest_out, e.dest);
        check("div_zero", mif.div_zero, e.dz);
        check("latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst && mif.busy)
      assert (!mif.start) else $error("start asserted while busy");
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp_res);
    exp_t e;
    int   stall_cnt;
    bit   seen;
    bit   early;
    early = early_en && ((a == 0) || (b == 0));
    e.res  = exp_res;
    e.dest = d;
    e.dz   = op[1] && (b == 0);
    e.cyc  = cyc + 1 + (early ? 1 : W + 1);
    sbq.push_back(e);
    mif.start = 1'b1; mif.op = op; mif.op_a = a; mif.op_b = b; mif.dest_in = d;
    #1;
    stall_cnt = mif.stall ? 1 : 0;
    @(negedge clk);
    mif.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (mif.result_valid) begin
        seen = 1;
        break;
      end
      if (mif.stall) stall_cnt++;
      @(negedge clk);
    end
    check("valid_seen", seen, 1);
    check("stall_cycles", stall_cnt, early ? 1 : W + 1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rd;
`ifdef MULDIV_EARLY_OUT_EN
    early_en = 1'b1;
`else
    early_en = 1'b0;
`endif
    rst = 1'b0;
    mif.start = 0; mif.op = 0; mif.op_a = 0; mif.op_b = 0; mif.dest_in = 0; mif.flush = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", mif.busy, 0);
    check("rst_valid", mif.result_valid, 0);
    check("rst_result", mif.result, 0);
    check("rst_stall", mif.stall, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
    @(negedge clk);
    #1;
    check("hold_result", mif.result, 32'hFFFF_FFEB);
    check("hold_dest", mif.dest_out, 5'd3);
    check("valid_one_cycle", mif.result_valid, 0);
    run_op(2'b01, 32'd7, 32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFFF);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h0000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0);
    run_op(2'b10, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd5, 32'd0, 5'd12, 32'd5);
    run_op(2'b00, 32'd0, 32'd1234, 5'd13, 32'd0);

    // Flush a divide partway through, then issue immediately afterwards.
    mif.start = 1; mif.op = 2'b10; mif.op_a = 32'd100; mif.op_b = 32'd7; mif.dest_in = 5'd14;
    @(negedge clk);
    mif.start = 0;
    repeat (10) @(negedge clk);
    mif.flush = 1;
    #1;
    check("flush_stall", mif.stall, 0);
    check("flush_busy_before", mif.busy, 1);
    @(negedge clk);
    mif.flush = 0;
    #1;
    check("flush_idle", mif.busy, 0);
    check("flush_no_valid", mif.result_valid, 0);
    run_op(2'b00, 32'd3, 32'd4, 5'd15, 32'd12);

    // Reset in the middle of an operation, with start held during reset.
    mif.start = 1; mif.op = 2'b01; mif.op_a = 32'd99; mif.op_b = 32'd77; mif.dest_in = 5'd16;
    @(negedge clk);
    mif.start = 0;
    repeat (8) @(negedge clk);
    rst = 0;
    mif.start = 1;
    @(negedge clk);
    #1;
    check("midrst_result", mif.result, 0);
    check("midrst_dest", mif.dest_out, 0);
    check("midrst_busy", mif.busy, 0);
    check("midrst_valid", mif.result_valid, 0);
    check("midrst_dz", mif.div_zero, 0);
    check("midrst_stall", mif.stall, 0);
    @(negedge clk);
    #1;
    check("rst_start_ignored", mif.busy, 0);
    rst = 1;
    mif.start = 0;
    @(negedge clk);
    #1;
    check("post_rst_idle", mif.busy, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      rd  = 5'($urandom_range(0, 31));
      run_op(rop, ra, rb, rd, ref_res(rop, ra, rb));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
